// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, instruction size and the
// IF/ID register layout that the decode stage also consumes.
package pipeline_pkg;

  localparam int PC_W        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [ILEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_pc_unit_adder.sv
// Shared combinational adder; the fetch stage uses it for PC + 4.
// The sum wraps modulo 2^WIDTH.
module Adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);

  assign out = a + b;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues variable-latency requests to
// instruction memory and loads IF/ID. A redirect that lands while a request
// is outstanding lets the wrong-path transaction finish (DISCARD) before the
// target is requested, so no memory request is ever abandoned.
module fetch_pc_unit
  import pipeline_pkg::*;
#(
  parameter int               WIDTH    = 64,
  parameter int               INSTR_W  = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [WIDTH-1:0]   branch_target,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [WIDTH-1:0]   ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [31:0]        fetch_count
);

  fetch_state_t       state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  if_id_t             ifid_q, ifid_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]   pc_plus4_s;
  logic [WIDTH-1:0]   tgt_s;

  Adder #(.WIDTH(WIDTH)) u_pc_adder (
    .a   (pc_q),
    .b   (WIDTH'(INSTR_BYTES)),
    .out (pc_plus4_s)
  );

  // Redirect addresses are always word aligned.
  assign tgt_s = branch_target & {{(WIDTH-2){1'b1}}, 2'b00};

  // Next-state, next-PC and IF/ID load decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (branch_taken) begin
          pc_d         = tgt_s;
          ifid_d.valid = 1'b0;
        end else begin
          pc_d = pc_q;
        end
      end
      FETCH: begin
        if (branch_taken) begin
          ifid_d.valid = 1'b0;
          if (imem_ready) begin
            pc_d = tgt_s;
          end else begin
            pend_d  = tgt_s;
            state_d = DISCARD;
          end
        end else if (stall) begin
          if (imem_ready) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end else begin
            state_d = FETCH;
          end
        end else if (imem_ready) begin
          ifid_d.valid = 1'b1;
          ifid_d.pc    = PC_W'(pc_q);
          ifid_d.instr = ILEN'(imem_rdata);
          pc_d         = pc_plus4_s;
          cnt_d        = cnt_q + 32'd1;
        end else begin
          ifid_d.valid = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          ifid_d.valid = 1'b0;
          pc_d         = tgt_s;
          state_d      = FETCH;
        end else if (stall) begin
          state_d = HOLD;
        end else begin
          ifid_d.valid = 1'b1;
          ifid_d.pc    = PC_W'(pc_q);
          ifid_d.instr = ILEN'(buf_q);
          pc_d         = pc_plus4_s;
          cnt_d        = cnt_q + 32'd1;
          state_d      = FETCH;
        end
      end
      DISCARD: begin
        ifid_d.valid = 1'b0;
        if (branch_taken) begin
          pend_d = tgt_s;
        end else begin
          pend_d = pend_q;
        end
        if (imem_ready) begin
          pc_d    = branch_taken ? tgt_s : pend_q;
          state_d = FETCH;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All stage registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= {WIDTH{1'b0}};
      buf_q   <= {INSTR_W{1'b0}};
      ifid_q  <= '0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request valid is decoded from the registered state.
  always_comb begin
    case (state_q)
      FETCH, DISCARD: imem_req = 1'b1;
      default:        imem_req = 1'b0;
    endcase
  end

  assign imem_addr   = pc_q;
  assign ifid_valid  = ifid_q.valid;
  assign ifid_pc     = WIDTH'(ifid_q.pc);
  assign ifid_instr  = INSTR_W'(ifid_q.instr);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, zero-wait streaming, wait states,
// stall/HOLD, redirect into DISCARD, repeated redirects, PC wrap and reset
// in the middle of a transaction.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_pc_unit #(
    .WIDTH   (64),
    .INSTR_W (32),
    .RESET_PC(64'h400)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== 64'h400) begin bad++; $display("FAIL rst_addr got=%h exp=400", imem_addr); end
    total++; if ({ifid_valid, ifid_pc, ifid_instr} !== 97'h0) begin bad++; $display("FAIL rst_ifid got=%b/%h/%h exp=0", ifid_valid, ifid_pc, ifid_instr); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_zero_wait();
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hA000_0000;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL zw_idle_req got=%b exp=0", imem_req); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h400 || ifid_valid !== 1'b0) begin bad++; $display("FAIL zw_first got=%b/%h/%b exp=1/400/0", imem_req, imem_addr, ifid_valid); end
    imem_rdata = 32'hA000_0001;
    tick();
    total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h400 || ifid_instr !== 32'hA000_0001) begin bad++; $display("FAIL zw_load0 got=%b/%h/%h exp=1/400/a0000001", ifid_valid, ifid_pc, ifid_instr); end
    total++; if (imem_addr !== 64'h404) begin bad++; $display("FAIL zw_addr1 got=%h exp=404", imem_addr); end
    imem_rdata = 32'hA000_0002;
    tick();
    total++; if (ifid_pc !== 64'h404 || imem_addr !== 64'h408) begin bad++; $display("FAIL zw_load1 got=%h/%h exp=404/408", ifid_pc, imem_addr); end
    imem_rdata = 32'hA000_0003;
    tick();
    total++; if (ifid_pc !== 64'h408 || ifid_instr !== 32'hA000_0003 || fetch_count !== 32'd3) begin bad++; $display("FAIL zw_load2 got=%h/%h/%0d exp=408/a0000003/3", ifid_pc, ifid_instr, fetch_count); end
    imem_ready = 1'b0;
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 64'h40C || ifid_valid !== 1'b0) begin bad++; $display("FAIL wait_bubble%0d got=%b/%h/%b exp=1/40c/0", i, imem_req, imem_addr, ifid_valid); end
    end
    imem_ready = 1'b1; imem_rdata = 32'hB000_0003;
    tick();
    total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h40C || ifid_instr !== 32'hB000_0003 || fetch_count !== 32'd4 || imem_addr !== 64'h410) begin bad++; $display("FAIL wait_load got=%b/%h/%h/%0d/%h exp=1/40c/b0000003/4/410", ifid_valid, ifid_pc, ifid_instr, fetch_count, imem_addr); end
    imem_ready = 1'b0;
  endtask

  task automatic test_stall_hold();
    stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hC000_0004;
    tick();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 64'h40C || ifid_instr !== 32'hB000_0003 || fetch_count !== 32'd4) begin bad++; $display("FAIL hold_keep%0d got=%b/%b/%h/%h/%0d exp=0/1/40c/b0000003/4", i, imem_req, ifid_valid, ifid_pc, ifid_instr, fetch_count); end
      if (i == 2) stall = 1'b0;
      tick();
    end
    total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h410 || ifid_instr !== 32'hC000_0004 || fetch_count !== 32'd5 || imem_addr !== 64'h414 || imem_req !== 1'b1) begin bad++; $display("FAIL hold_release got=%b/%h/%h/%0d/%h/%b exp=1/410/c0000004/5/414/1", ifid_valid, ifid_pc, ifid_instr, fetch_count, imem_addr, imem_req); end
    imem_ready = 1'b1; imem_rdata = 32'hC000_0005;
    tick();
    total++; if (ifid_pc !== 64'h414 || ifid_instr !== 32'hC000_0005 || fetch_count !== 32'd6) begin bad++; $display("FAIL hold_next got=%h/%h/%0d exp=414/c0000005/6", ifid_pc, ifid_instr, fetch_count); end
    imem_ready = 1'b0;
  endtask

  task automatic test_branch_discard();
    branch_taken = 1'b1; branch_target = 64'h1002;
    tick();
    branch_taken = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h418 || ifid_valid !== 1'b0) begin bad++; $display("FAIL disc_enter got=%b/%h/%b exp=1/418/0", imem_req, imem_addr, ifid_valid); end
    tick();
    total++; if (imem_addr !== 64'h418 || ifid_valid !== 1'b0) begin bad++; $display("FAIL disc_wait got=%h/%b exp=418/0", imem_addr, ifid_valid); end
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_0000;
    tick();
    imem_ready = 1'b0;
    total++; if (imem_addr !== 64'h1000 || ifid_valid !== 1'b0 || fetch_count !== 32'd6 || imem_req !== 1'b1) begin bad++; $display("FAIL disc_resume got=%h/%b/%0d/%b exp=1000/0/6/1", imem_addr, ifid_valid, fetch_count, imem_req); end
  endtask

  task automatic test_back_to_back_branches();
    branch_taken = 1'b1; branch_target = 64'h2000;
    tick();
    branch_target = 64'h3000;
    tick();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 64'h1000 || ifid_valid !== 1'b0) begin bad++; $display("FAIL b2b_held got=%h/%b exp=1000/0", imem_addr, ifid_valid); end
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    total++; if (imem_addr !== 64'h3000 || ifid_valid !== 1'b0) begin bad++; $display("FAIL b2b_target got=%h/%b exp=3000/0", imem_addr, ifid_valid); end
    imem_rdata = 32'hE000_0006;
    tick();
    imem_ready = 1'b0;
    total++; if (ifid_pc !== 64'h3000 || ifid_instr !== 32'hE000_0006 || fetch_count !== 32'd7) begin bad++; $display("FAIL b2b_load got=%h/%h/%0d exp=3000/e0000006/7", ifid_pc, ifid_instr, fetch_count); end
    // A redirect that coincides with the wrong-path completion wins over pend.
    branch_taken = 1'b1; branch_target = 64'h5000;
    tick();
    branch_target = 64'h6000; imem_ready = 1'b1;
    tick();
    branch_taken = 1'b0; imem_ready = 1'b0;
    total++; if (imem_addr !== 64'h6000 || ifid_valid !== 1'b0) begin bad++; $display("FAIL disc_same_cycle got=%h/%b exp=6000/0", imem_addr, ifid_valid); end
  endtask

  task automatic test_wrap_and_branch_stall();
    imem_ready = 1'b1; imem_rdata = 32'hF000_0007;
    tick();
    total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h6000 || fetch_count !== 32'd8) begin bad++; $display("FAIL wrap_pre got=%b/%h/%0d exp=1/6000/8", ifid_valid, ifid_pc, fetch_count); end
    branch_taken = 1'b1; stall = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFE; imem_rdata = 32'hBAD0_0002;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    total++; if (ifid_valid !== 1'b0 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || fetch_count !== 32'd8) begin bad++; $display("FAIL br_stall got=%b/%h/%0d exp=0/fffffffffffffffc/8", ifid_valid, imem_addr, fetch_count); end
    imem_rdata = 32'hF000_0008;
    tick();
    imem_ready = 1'b0;
    total++; if (ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ifid_instr !== 32'hF000_0008 || imem_addr !== 64'h0 || fetch_count !== 32'd9) begin bad++; $display("FAIL wrap got=%h/%h/%h/%0d exp=fffffffffffffffc/f0000008/0/9", ifid_pc, ifid_instr, imem_addr, fetch_count); end
  endtask

  task automatic test_reset_mid();
    tick();
    reset = 1'b1;
    tick();
    total++; if (imem_req !== 1'b0 || imem_addr !== 64'h400 || ifid_valid !== 1'b0 || fetch_count !== 32'd0) begin bad++; $display("FAIL mid_rst got=%b/%h/%b/%0d exp=0/400/0/0", imem_req, imem_addr, ifid_valid, fetch_count); end
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hBAD0_0003;
    tick();
    imem_ready = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h400 || ifid_valid !== 1'b0 || fetch_count !== 32'd0) begin bad++; $display("FAIL mid_late got=%b/%h/%b/%0d exp=1/400/0/0", imem_req, imem_addr, ifid_valid, fetch_count); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_branch_discard();
    test_back_to_back_branches();
    test_wrap_and_branch_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the 64-bit pipeline. Holds the program counter and issues requests to instruction memory, which may respond in a variable number of cycles. Computes PC+4 through the shared 64-bit `Adder` and loads the IF/ID pipeline register. Handles stalls from the hazard unit and taken-branch redirects from later stages, including a redirect that arrives while a memory request is still outstanding.

## Interface
Parameters:
- `WIDTH`, 64, address/PC width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 64'h0, PC value loaded on reset

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high reset
- `stall` in 1: hazard unit request to hold PC and IF/ID
- `branch_taken` in 1: redirect request from a later stage
- `branch_target` in WIDTH: redirect address
- `imem_req` out 1: fetch request valid
- `imem_addr` out WIDTH: fetch address; always equal to the PC register
- `imem_ready` in 1: memory response valid for one cycle; data on `imem_rdata`
- `imem_rdata` in INSTR_W: fetched instruction
- `ifid_valid` out 1: IF/ID holds a real instruction
- `ifid_pc` out WIDTH: PC of the IF/ID instruction
- `ifid_instr` out INSTR_W: IF/ID instruction
- `fetch_count` out 32: count of instructions loaded into IF/ID; wraps at 2^32

## Operation
FSM states: IDLE, FETCH, HOLD, DISCARD.

Decoded outputs:
- `imem_req`=1 in FETCH and DISCARD only.
- The request is held with a stable address until `imem_ready` is sampled high.

Reset:
- state=IDLE, pc=`RESET_PC`, `imem_req`=0, `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=0, `fetch_count`=0.
- hold buffer and pending-target registers are cleared to 0.

Priority in every state: reset > `branch_taken` > `stall` > normal progress.
- A taken branch always loads `ifid_valid`<=0, even when `stall`=1.
- `stall`=1 with no branch holds `ifid_*` unchanged.

State behaviour:
- IDLE
  - → FETCH.
  - `branch_taken`: pc<=target.
- FETCH
  - `branch_taken` && `imem_ready`: drop data, pc<=target, stay in FETCH.
  - `branch_taken` && !`imem_ready`: pend<=target, → DISCARD.
  - `imem_ready` && !`stall`: IF/ID<={pc, rdata, valid=1}, pc<=pc+4, `fetch_count`++.
  - `imem_ready` && `stall`: buffer<=rdata, → HOLD.
  - !`imem_ready` && !`stall`: `ifid_valid`<=0 (bubble).
- HOLD (request deasserted)
  - `branch_taken`: drop buffer, pc<=target, → FETCH.
  - !`stall`: IF/ID<={pc, buffer, 1}, pc<=pc+4, `fetch_count`++, → FETCH.
- DISCARD
  - `imem_addr` stays at the old pc; `ifid_valid` stays 0.
  - A new `branch_taken` overwrites pend (newest wins).
  - `imem_ready`: data dropped, pc<=pend, or `branch_target` if `branch_taken` in the same cycle; → FETCH.

Arithmetic:
- pc+4 comes from `Adder` (a=pc, b=4) and wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC → 0).
- `branch_target[1:0]` is forced to 2'b00 wherever it is loaded into pc or pend.

## Timing
- `imem_ready` may be asserted in the same cycle the request is first presented (zero-wait memory). That gives one instruction per cycle into IF/ID.
- Fetch latency is request cycle plus memory wait cycles. IF/ID updates on the edge that samples `imem_ready`.
- First request is presented the cycle after reset deasserts (IDLE costs one cycle).
- A branch costs at least one bubble: the IF/ID load at the branch edge is squashed. The target is requested in the next cycle.
- In DISCARD, the wrong-path transaction always completes before the target is requested. No request is ever abandoned.
- Reset mid-transaction: the next edge returns to IDLE. Any late `imem_ready` is ignored in IDLE.
- `fetch_count` increments only on `ifid_valid`<=1 loads.

## Structure
- Shared package `pipeline_pkg` holds:
  - `fetch_state_t` enum (IDLE, FETCH, HOLD, DISCARD)
  - `INSTR_BYTES`=4
  - the `if_id_t` struct {valid, pc, instr}, reused by the decode stage
- One sub-module: the existing `Adder` (ports a, b, out) for PC+4.
- All registers live in a single clocked process. Next-state and next-PC logic is combinational.

## Test plan
- Reset with `RESET_PC`=64'h400 and zero-wait memory → `imem_addr` sequence 400, 404, 408. `ifid_valid` rises the second cycle after reset release. `fetch_count`=3 after three loads.
- `imem_ready` delayed 2 cycles per request → `imem_addr` held stable. `ifid_valid`=0 bubbles in wait cycles with `stall`=0.
- `stall`=1 for 3 cycles while a response arrives → HOLD entered and `ifid_*` unchanged. The buffered instruction appears in IF/ID the edge `stall` drops, with no duplicate or lost instruction.
- `branch_taken` with target 64'h1002 while a request is outstanding → DISCARD. Late data is dropped, then `imem_addr`=64'h1000. `ifid_valid`=0 throughout.
- Two branches during DISCARD (targets 64'h2000, then 64'h3000) → fetch resumes at 64'h3000.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetched → next `imem_addr`=0. `branch_taken` and `stall` in the same cycle → `ifid_valid`=0 and pc=target.
